// File: rtl/bp_stall_counter_bank.sv
// Per-cycle stall-reason histogram with instret and cycle counters.
// Counters are read through a single-outstanding valid/ready port with optional read-and-clear.
module bp_stall_counter_bank #(
  parameter int num_reasons_p = 24,
  parameter int cnt_width_p   = 32,
  parameter int addr_width_p  = 5
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    freeze_i,
  input  logic                    commit_v_i,
  input  logic [4:0]              stall_reason_i,
  input  logic                    clear_i,
  input  logic                    rd_v_i,
  input  logic [addr_width_p-1:0] rd_addr_i,
  input  logic                    rd_clear_i,
  output logic                    rd_ready_o,
  output logic                    rd_v_o,
  output logic [cnt_width_p-1:0]  rd_data_o,
  input  logic                    rd_yumi_i
);
  localparam int num_cnt_lp     = num_reasons_p + 2;
  localparam int instret_idx_lp = num_reasons_p;
  localparam int cycle_idx_lp   = num_reasons_p + 1;

  logic [cnt_width_p-1:0] r_cnt [num_cnt_lp];
  logic                   r_rd_v;
  logic [cnt_width_p-1:0] r_rd_data;

  logic                   w_accept;
  logic [num_cnt_lp-1:0]  w_inc;
  logic [num_cnt_lp-1:0]  w_rd_clr;
  logic [cnt_width_p-1:0] w_rd_val;

  assign rd_ready_o = ~reset_i & (~r_rd_v | rd_yumi_i);
  assign w_accept   = rd_v_i & rd_ready_o;
  assign rd_v_o     = r_rd_v;
  assign rd_data_o  = r_rd_data;

  always_comb begin
    w_inc = '0;
    w_inc[cycle_idx_lp]   = ~freeze_i;
    w_inc[instret_idx_lp] = ~freeze_i & commit_v_i;
    if (~freeze_i & ~commit_v_i) begin
      // Unencodable reasons are folded into the "unknown" bucket.
      if (int'(stall_reason_i) >= num_reasons_p) begin
        w_inc[0] = 1'b1;
      end else begin
        for (int k = 0; k < num_reasons_p; k++) begin
          if (int'(stall_reason_i) == k) w_inc[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    w_rd_clr = '0;
    for (int k = 0; k < num_cnt_lp; k++) begin
      if (int'(rd_addr_i) == k) begin
        w_rd_val    = r_cnt[k];
        w_rd_clr[k] = w_accept & rd_clear_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < num_cnt_lp; k++) r_cnt[k] <= '0;
      r_rd_v    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      // Global clear beats everything; read-and-clear lets a same-cycle increment land afterwards.
      for (int k = 0; k < num_cnt_lp; k++) begin
        if (clear_i)                            r_cnt[k] <= '0;
        else if (w_rd_clr[k])                   r_cnt[k] <= cnt_width_p'(w_inc[k]);
        else if (w_inc[k] && (r_cnt[k] != '1)) r_cnt[k] <= r_cnt[k] + cnt_width_p'(1);
      end
      if (w_accept) begin
        r_rd_v    <= 1'b1;
        r_rd_data <= w_rd_val;
      end else if (rd_yumi_i) begin
        r_rd_v    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bp_stall_counter_bank.sv
// Scoreboard bench for bp_stall_counter_bank; a second 8-bit instance shares the stimulus
// so saturation can be reached quickly.
module tb_bp_stall_counter_bank;
  logic        clk = 0, rst = 1, freeze = 1, commit = 0, clr = 0;
  logic        rd_v = 0, rd_clear = 0, rd_yumi = 0;
  logic [4:0]  reason = 0, rd_addr = 0;
  logic        rdy, vo, rdy8, vo8;
  logic [31:0] data;
  logic [7:0]  data8;
  int          n_vec = 0, n_err = 0;
  logic [31:0] sb_q [$];

  always #5 clk = ~clk;

  bp_stall_counter_bank dut (
    .clk_i(clk), .reset_i(rst), .freeze_i(freeze), .commit_v_i(commit),
    .stall_reason_i(reason), .clear_i(clr), .rd_v_i(rd_v), .rd_addr_i(rd_addr),
    .rd_clear_i(rd_clear), .rd_ready_o(rdy), .rd_v_o(vo), .rd_data_o(data),
    .rd_yumi_i(rd_yumi)
  );

  bp_stall_counter_bank #(.cnt_width_p(8)) dut8 (
    .clk_i(clk), .reset_i(rst), .freeze_i(freeze), .commit_v_i(commit),
    .stall_reason_i(reason), .clear_i(clr), .rd_v_i(rd_v), .rd_addr_i(rd_addr),
    .rd_clear_i(rd_clear), .rd_ready_o(rdy8), .rd_v_o(vo8), .rd_data_o(data8),
    .rd_yumi_i(rd_yumi)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    clr = 1; cyc(); clr = 0;
  endtask

  // Present one request until accepted and record what it must return.
  task automatic issue(input logic [4:0] a, input logic c, input logic [31:0] exp);
    int t = 0;
    rd_addr = a; rd_clear = c; rd_v = 1;
    while (!rdy && t < 20) begin cyc(); t++; end
    sb_q.push_back(exp);
    cyc();
    rd_v = 0; rd_clear = 0;
  endtask

  // Wait (bounded) for the response, hand back observed and expected, then consume it.
  task automatic get(output logic [31:0] got, output logic [31:0] exp);
    int t = 0;
    while (!vo && t < 20) begin cyc(); t++; end
    got = vo ? data : 32'hxxxx_xxxx;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hdead_beef;
    rd_yumi = 1; cyc(); rd_yumi = 0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", rdy); end
    n_vec++; if (vo !== 1'b0) begin n_err++; $display("FAIL reset_v got %b want 0", vo); end
    n_vec++; if (data !== 32'd0) begin n_err++; $display("FAIL reset_data got %0d want 0", data); end
    #1; rst = 0;
    cyc();
    n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b want 1", rdy); end
  endtask

  task automatic test_basic();
    logic [31:0] e;
    int sum = 0;
    freeze = 0; reason = 6;
    for (int i = 0; i < 10; i++) begin commit = (i % 2 == 0); cyc(); end
    freeze = 1; commit = 0;
    rd_v = 1;
    for (int a = 0; a < 26; a++) begin
      rd_addr = 5'(a);
      sb_q.push_back((a == 6) ? 32'd5 : (a == 24) ? 32'd5 : (a == 25) ? 32'd10 : 32'd0);
      cyc();
      rd_yumi = 1;
      e = sb_q.pop_front();
      n_vec++;
      if (vo !== 1'b1 || data !== e) begin
        n_err++; $display("FAIL basic_b2b addr %0d got v=%b %0d want v=1 %0d", a, vo, data, e);
      end
      if (a < 25) sum += int'(data);
    end
    rd_v = 0; cyc(); rd_yumi = 0;
    n_vec++; if (sum != 10) begin n_err++; $display("FAIL invariant got %0d want 10", sum); end
  endtask

  task automatic test_freeze_oor();
    logic [31:0] got, e;
    logic [4:0]  addrs [5];
    addrs = '{5'd0, 5'd25, 5'd24, 5'd31, 5'd30};
    clear_all();
    commit = 1; repeat (8) cyc();
    commit = 0; reason = 30; freeze = 0; repeat (4) cyc();
    freeze = 1;
    for (int i = 0; i < 5; i++) begin
      issue(addrs[i], 1'b0, (i < 2) ? 32'd4 : 32'd0);
      get(got, e);
      n_vec++; if (got !== e) begin n_err++; $display("FAIL freeze_oor addr %0d got %0d want %0d", addrs[i], got, e); end
    end
  endtask

  task automatic test_rdclr_collision();
    logic [31:0] got, e;
    clear_all();
    freeze = 0; commit = 0; reason = 11;
    repeat (7) cyc();
    issue(5'd11, 1'b1, 32'd7);
    freeze = 1;
    get(got, e);
    n_vec++; if (got !== e) begin n_err++; $display("FAIL rdclr_resp got %0d want %0d", got, e); end
    issue(5'd11, 1'b0, 32'd1);
    get(got, e);
    n_vec++; if (got !== e) begin n_err++; $display("FAIL rdclr_after got %0d want %0d", got, e); end
    issue(5'd25, 1'b0, 32'd8);
    get(got, e);
    n_vec++; if (got !== e) begin n_err++; $display("FAIL rdclr_cycles got %0d want %0d", got, e); end
  endtask

  task automatic test_global_clear();
    logic [31:0] got, e;
    logic [4:0]  addrs [3];
    addrs = '{5'd3, 5'd25, 5'd24};
    clear_all();
    freeze = 0; commit = 0; reason = 3;
    repeat (50) cyc();
    clr = 1;
    issue(5'd25, 1'b0, 32'd50);
    clr = 0; freeze = 1;
    get(got, e);
    n_vec++; if (got !== e) begin n_err++; $display("FAIL gclr_resp got %0d want %0d", got, e); end
    for (int i = 0; i < 3; i++) begin
      issue(addrs[i], 1'b0, 32'd0);
      get(got, e);
      n_vec++; if (got !== e) begin n_err++; $display("FAIL gclr_zero addr %0d got %0d want %0d", addrs[i], got, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    clear_all();
    freeze = 0; commit = 1; repeat (3) cyc();
    commit = 0; reason = 5; repeat (2) cyc();
    freeze = 1;
    issue(5'd24, 1'b0, 32'd3);
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (rdy !== 1'b0 || vo !== 1'b1 || data !== 32'd3) begin
        n_err++; $display("FAIL hold cyc %0d got rdy=%b v=%b %0d want rdy=0 v=1 3", i, rdy, vo, data);
      end
      cyc();
    end
    e = sb_q.pop_front();
    n_vec++; if (data !== e) begin n_err++; $display("FAIL hold_data got %0d want %0d", data, e); end
    rd_yumi = 1; rd_v = 1; rd_addr = 5'd25;
    #1;
    n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL yumi_ready got %b want 1", rdy); end
    sb_q.push_back(32'd5);
    cyc();
    rd_v = 0; rd_yumi = 0;
    e = sb_q.pop_front();
    n_vec++; if (vo !== 1'b1 || data !== e) begin n_err++; $display("FAIL b2b_resp got v=%b %0d want v=1 %0d", vo, data, e); end
    rd_yumi = 1; cyc(); rd_yumi = 0;
    n_vec++; if (vo !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b want 0", vo); end
  endtask

  task automatic test_saturation();
    logic [31:0] got, e;
    clear_all();
    freeze = 0; commit = 0; reason = 2;
    repeat (258) cyc();
    freeze = 1;
    issue(5'd2, 1'b0, 32'd258);
    e = sb_q.pop_front();
    n_vec++; if (data !== e) begin n_err++; $display("FAIL sat_wide got %0d want %0d", data, e); end
    n_vec++; if (vo8 !== 1'b1 || data8 !== 8'd255) begin n_err++; $display("FAIL sat_narrow got v=%b %0d want v=1 255", vo8, data8); end
    #2; rst = 1; #1;
    n_vec++;
    if (vo !== 1'b0 || rdy !== 1'b0 || vo8 !== 1'b0 || rdy8 !== 1'b0 || data !== 32'd0) begin
      n_err++; $display("FAIL mid_reset got v=%b rdy=%b v8=%b rdy8=%b d=%0d want 0s", vo, rdy, vo8, rdy8, data);
    end
    cyc(); cyc();
    rst = 0;
    cyc();
    n_vec++; if (vo !== 1'b0 || vo8 !== 1'b0) begin n_err++; $display("FAIL post_reset_resp got v=%b v8=%b want 0", vo, vo8); end
    issue(5'd2, 1'b0, 32'd0);
    get(got, e);
    n_vec++; if (got !== e || data8 !== 8'd0) begin n_err++; $display("FAIL sat_after_reset got %0d/%0d want %0d/0", got, data8, e); end
    issue(5'd25, 1'b0, 32'd0);
    get(got, e);
    n_vec++; if (got !== e) begin n_err++; $display("FAIL cycles_after_reset got %0d want %0d", got, e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_freeze_oor();
    test_rdclr_collision();
    test_global_clear();
    test_back_to_back();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
